frame_scan_ctrl: RTL

- Control stage directly upstream of the frame buffer block.
- Accepts a byte stream from the pixel source and tracks each byte's raster position within the full 330x110 capture frame (blanking included).
- Drives the buffer's write-advance strobe.
- Once a full frame is captured, sequences the cropped 300x100 active-region readout by issuing readFrame plus a linear output index FrameWInd.

---
 rtl/frame_scan_pkg.sv | 20 ++
 rtl/frame_scan_ctrl_pos.sv | 52 +++++
 rtl/frame_scan_ctrl.sv | 101 ++++++++++
 3 files changed

// File: rtl/frame_scan_pkg.sv
// Shared types and default geometry for the frame scan controller.
package frame_scan_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam int unsigned H_TOTAL_DEF  = 330;
  localparam int unsigned V_TOTAL_DEF  = 110;
  localparam int unsigned H_ACTIVE_DEF = 300;
  localparam int unsigned V_ACTIVE_DEF = 100;
  localparam int unsigned POS_W        = 10;

  localparam int unsigned FRAME_BYTES = H_TOTAL_DEF * V_TOTAL_DEF;
  localparam int unsigned ACTIVE_PIX  = H_ACTIVE_DEF * V_ACTIVE_DEF;

endpackage

// File: rtl/frame_scan_ctrl_pos.sv
// frame_pos_counter: horizontal/vertical raster wrap counter with enable.
// last_o flags the final position of the frame (both counters at their maximum).
module frame_pos_counter
  import frame_scan_pkg::*;
#(
  parameter int unsigned H_MAX = H_TOTAL_DEF,
  parameter int unsigned V_MAX = V_TOTAL_DEF,
  parameter int unsigned W     = POS_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en_i,
  output logic [W-1:0] px_o,
  output logic [W-1:0] line_o,
  output logic         last_o
);

  logic [W-1:0] px_q, px_d;
  logic [W-1:0] line_q, line_d;
  logic         h_last, v_last;

  assign h_last = (px_q == W'(H_MAX - 1));
  assign v_last = (line_q == W'(V_MAX - 1));

  always_comb begin
    px_d   = px_q;
    line_d = line_q;
    if (en_i) begin
      if (h_last) begin
        px_d   = '0;
        line_d = v_last ? '0 : line_q + 1'b1;
      end else begin
        px_d = px_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      px_q   <= '0;
      line_q <= '0;
    end else begin
      px_q   <= px_d;
      line_q <= line_d;
    end
  end

  assign px_o   = px_q;
  assign line_o = line_q;
  assign last_o = h_last & v_last;

endmodule

// File: rtl/frame_scan_ctrl.sv
// Capture-then-readout sequencer in front of the frame buffer.
// Optional FRAME_SCAN_AUTO_RESTART_EN: DONE returns to WRITE instead of IDLE.
module frame_scan_ctrl
  import frame_scan_pkg::*;
#(
  parameter int unsigned H_TOTAL  = H_TOTAL_DEF,
  parameter int unsigned V_TOTAL  = V_TOTAL_DEF,
  parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
  parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
  parameter int unsigned IDX_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             PixValid,
  output logic             PixReady,
  output logic             IncIndex,
  output logic [9:0]       PxOut,
  output logic [9:0]       LineOut,
  output logic             readFrame,
  output logic [IDX_W-1:0] FrameWInd,
  output logic             FrameDone
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(H_ACTIVE * V_ACTIVE - 1);

  generate
    if (64'(H_ACTIVE) * 64'(V_ACTIVE) > (64'd1 << IDX_W)) begin : g_bad_idx_w
      $error("frame_scan_ctrl: H_ACTIVE*V_ACTIVE does not fit in IDX_W bits");
    end
    if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_geometry
      $error("frame_scan_ctrl: H_TOTAL/V_TOTAL exceed 10-bit position range");
    end
  endgenerate

  state_e           state_q, state_d;
  logic             read_q, read_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             done_q, done_d;
  logic             frame_last;

  assign PixReady = (state_q == ST_WRITE);
  assign IncIndex = PixValid & PixReady;

  frame_pos_counter #(
    .H_MAX (H_TOTAL),
    .V_MAX (V_TOTAL),
    .W     (POS_W)
  ) u_pos (
    .clk    (clk),
    .reset  (reset),
    .en_i   (IncIndex),
    .px_o   (PxOut),
    .line_o (LineOut),
    .last_o (frame_last)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (start) state_d = ST_WRITE;
      ST_WRITE: if (IncIndex && frame_last) state_d = ST_READ;
      ST_READ:  if (idx_q == LAST_IDX) state_d = ST_DONE;
`ifdef FRAME_SCAN_AUTO_RESTART_EN
      ST_DONE:  state_d = ST_WRITE;
`else
      ST_DONE:  state_d = ST_IDLE;
`endif
      default:  state_d = ST_IDLE;
    endcase
  end

  // Readout outputs are registered from the next state so they align with it.
  always_comb begin
    read_d = (state_d == ST_READ);
    done_d = (state_d == ST_DONE);
    idx_d  = '0;
    if (state_q == ST_READ && state_d == ST_READ) begin
      idx_d = idx_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      read_q  <= 1'b0;
      idx_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      read_q  <= read_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
    end
  end

  assign readFrame = read_q;
  assign FrameWInd = idx_q;
  assign FrameDone = done_q;

endmodule
